// File: rtl/instr_packer_pkg.sv
// instr_pkg: shared state, format, error-code and opcode constants for instr_packer
package instr_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_ERROR} state_t;
  localparam logic FMT_B = 1'b0;
  localparam logic FMT_I = 1'b1;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_I    = 2'd1;
  localparam logic [1:0] ERR_B    = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
endpackage

// File: rtl/instr_packer_if.sv
// instr_packer_if: field-bundle handshake, memory write port and status of instr_packer
interface instr_packer_if #(parameter int ADDR_WIDTH = 8);
  logic                  restart;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_fmt;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rd;
  logic [31:0]           in_imm;
  logic                  in_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  modport master (
    output restart, in_valid, in_fmt, in_opcode, in_funct3, in_rs1, in_rd, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err, err_code
  );
  modport slave (
    input  restart, in_valid, in_fmt, in_opcode, in_funct3, in_rs1, in_rd, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, err, err_code
  );
endinterface

// File: rtl/instr_packer_imm_pack.sv
// imm_pack: places the immediate into I-type or branch-layout bit positions and range-checks it
module imm_pack import instr_pkg::*; (
  input  logic        i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic [1:0]  o_code
);
  logic w_i_ok, w_b_ok;
  assign w_i_ok = &i_imm[31:11] | ~|i_imm[31:11];
  assign w_b_ok = (&i_imm[31:12] | ~|i_imm[31:12]) & ~i_imm[0];
  assign o_word = (i_fmt == FMT_I) ? {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode}
                                   : {i_imm[12], i_imm[10:5], i_rd, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
  assign o_code = (i_fmt == FMT_I) ? (w_i_ok ? ERR_NONE : ERR_I) : (w_b_ok ? ERR_NONE : ERR_B);
endmodule

// File: rtl/instr_packer.sv
// instr_packer: accepts decoded fields, packs them into instruction words and writes them sequentially to memory
module instr_packer import instr_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input logic           clk,
  input logic           rst,
  instr_packer_if.slave bus
);
  state_t                r_state, w_next;
  logic [WIDTH-1:0]      r_word, w_word;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [1:0]            r_err_code, w_pack_code, w_code;
  logic                  r_last, w_accept;
  imm_pack u_pack (
    .i_fmt(bus.in_fmt), .i_opcode(bus.in_opcode), .i_funct3(bus.in_funct3),
    .i_rs1(bus.in_rs1), .i_rd(bus.in_rd), .i_imm(bus.in_imm),
    .o_word(w_word), .o_code(w_pack_code)
  );
  // overflow is judged on the word count, since the pointer wraps silently
  assign w_code   = r_count[ADDR_WIDTH] ? ERR_OVF : w_pack_code;
  assign w_accept = bus.in_valid && bus.in_ready && !bus.restart;
  always_comb begin
    w_next = bus.restart ? S_IDLE
           : w_accept ? ((w_code != ERR_NONE) ? S_ERROR : S_WRITE)
           : (r_state == S_WRITE) ? (r_last ? S_DONE : S_IDLE)
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= ADDR_WIDTH'(BASE_ADDR);
      r_count    <= '0;
      r_word     <= '0;
      r_last     <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (bus.restart) begin
      r_ptr      <= ADDR_WIDTH'(BASE_ADDR);
      r_count    <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_accept && w_code == ERR_NONE) begin
        r_word <= w_word;
        r_last <= bus.in_last;
      end
      if (w_accept) r_err_code <= w_code;
      if (r_state == S_WRITE) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end
  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.mem_we    = (r_state == S_WRITE) && !bus.restart && !rst;
  assign bus.mem_addr  = r_ptr;
  assign bus.mem_wdata = r_word;
  assign bus.count     = r_count;
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_ERROR);
  assign bus.err_code  = r_err_code;
endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed and random round-trip checks of instr_packer (ADDR_WIDTH=2, BASE_ADDR=1)
module tb_instr_packer;
  import instr_pkg::*;
  localparam int AW   = 2;
  localparam int BASE = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  instr_packer_if #(.ADDR_WIDTH(AW)) bus ();
  instr_packer #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ext(input logic [31:0] w, input logic fmt);
    return fmt ? {{20{w[31]}}, w[31:20]} : {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  // drives one bundle for a single cycle; returns at the negedge after the accepting edge
  task automatic send(input logic fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] imm, input logic last);
    bus.in_valid = 1'b1; bus.in_fmt = fmt; bus.in_opcode = op; bus.in_funct3 = f3;
    bus.in_rs1 = rs1; bus.in_rd = rd; bus.in_imm = imm; bus.in_last = last;
    chk("ready_before_send", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic do_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask
  initial begin
    logic [31:0] imm, r;
    logic        fmt;
    logic [4:0]  rs1;
    int          k;
    bus.restart = 1'b0; bus.in_valid = 1'b0; bus.in_fmt = 1'b0; bus.in_opcode = '0;
    bus.in_funct3 = '0; bus.in_rs1 = '0; bus.in_rd = '0; bus.in_imm = '0; bus.in_last = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'(BASE));
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_status", {29'd0, bus.done, bus.err_code}, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    send(FMT_I, OP_IMM, 3'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1);
    chk("addi_we", 32'(bus.mem_we), 32'd1);
    chk("addi_addr", 32'(bus.mem_addr), 32'(BASE));
    chk("addi_wdata", bus.mem_wdata, 32'hFFF0_0293);
    chk("addi_ready_low", 32'(bus.in_ready), 32'd0);
    chk("addi_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("addi_we_off", 32'(bus.mem_we), 32'd0);
    chk("addi_done", 32'(bus.done), 32'd1);
    chk("addi_count", 32'(bus.count), 32'd1);
    chk("addi_addr_inc", 32'(bus.mem_addr), 32'(BASE + 1));
    chk("addi_wdata_held", bus.mem_wdata, 32'hFFF0_0293);
    @(negedge clk);
    chk("done_sticky", {30'd0, bus.done, bus.in_ready}, 32'd2);
    do_restart();
    chk("rs_done", 32'(bus.done), 32'd0);
    chk("rs_count", 32'(bus.count), 32'd0);
    chk("rs_addr", 32'(bus.mem_addr), 32'(BASE));
    send(FMT_B, BRANCH, 3'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
    chk("br_we", 32'(bus.mem_we), 32'd1);
    chk("br_wdata", bus.mem_wdata, 32'hFE20_8EE3);
    chk("br_ext", ext(bus.mem_wdata, FMT_B), 32'hFFFF_FFFC);
    @(negedge clk);
    chk("br_count", 32'(bus.count), 32'd1);
    chk("br_idle_ready", 32'(bus.in_ready), 32'd1);
    send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd2, 32'd2048, 1'b0);
    chk("irange_err", 32'(bus.err), 32'd1);
    chk("irange_code", 32'(bus.err_code), 32'(ERR_I));
    chk("irange_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("err_sticky", {30'd0, bus.err, bus.in_ready}, 32'd2);
    chk("err_count", 32'(bus.count), 32'd1);
    do_restart();
    chk("rs_err_clear", {29'd0, bus.err, bus.err_code}, 32'd0);
    send(FMT_B, BRANCH, 3'd0, 5'd1, 5'd2, 32'd6, 1'b0);
    chk("b6_we", 32'(bus.mem_we), 32'd1);
    chk("b6_wdata", bus.mem_wdata, 32'h0020_8363);
    chk("b6_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    send(FMT_B, BRANCH, 3'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    chk("b3_code", 32'(bus.err_code), 32'(ERR_B));
    chk("b3_err", 32'(bus.err), 32'd1);
    chk("b3_we", 32'(bus.mem_we), 32'd0);
    do_restart();
    for (int i = 0; i < 4; i++) begin
      send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd3, 32'(i), 1'b0);
      chk("ovf_we", 32'(bus.mem_we), 32'd1);
      chk("ovf_addr", 32'(bus.mem_addr), 32'((BASE + i) % 4));
      @(negedge clk);
    end
    chk("ovf_count4", 32'(bus.count), 32'd4);
    send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd3, 32'd9, 1'b0);
    chk("ovf_code", 32'(bus.err_code), 32'(ERR_OVF));
    chk("ovf_no_write", 32'(bus.mem_we), 32'd0);
    chk("ovf_count_hold", 32'(bus.count), 32'd4);
    do_restart();
    send(FMT_I, OP_IMM, 3'd0, 5'd1, 5'd3, 32'd7, 1'b1);
    bus.restart = 1'b1;
    #1;
    chk("rsw_we_forced", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    bus.restart = 1'b0;
    chk("rsw_count", 32'(bus.count), 32'd0);
    chk("rsw_addr", 32'(bus.mem_addr), 32'(BASE));
    chk("rsw_idle", {30'd0, bus.done, bus.in_ready}, 32'd1);
    bus.restart = 1'b1; bus.in_valid = 1'b1; bus.in_fmt = FMT_I; bus.in_imm = 32'd1; bus.in_last = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0; bus.in_valid = 1'b0;
    chk("rsv_ready", 32'(bus.in_ready), 32'd1);
    chk("rsv_no_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("rsv_count", 32'(bus.count), 32'd0);
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      r   = $urandom;
      fmt = r[31];
      rs1 = r[20:16];
      imm = fmt ? {{20{r[11]}}, r[11:0]} : {{19{r[12]}}, r[12:1], 1'b0};
      send(fmt, fmt ? OP_IMM : BRANCH, r[15:13], rs1, r[25:21], imm, 1'b0);
      chk("rt_we", 32'(bus.mem_we), 32'd1);
      chk("rt_imm", ext(bus.mem_wdata, fmt), imm);
      chk("rt_rs1", 32'(bus.mem_wdata[19:15]), 32'(rs1));
      chk("rt_addr", 32'(bus.mem_addr), 32'((BASE + k) % 4));
      @(negedge clk);
      k++;
      if (k == 4) begin
        do_restart();
        k = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
